ques2_c: RTL and testbench
==========================

// Module: ques2_c
// PURPOSE
//   Registered 4-input Boolean function unit. Evaluates a fixed single-output function
//   f(a,b,c,d) defined by a 16-entry truth table and presents the result on a flop.
//   Used as a glitch-free, clocked decision bit in small control datapaths.
//   The default function is f = (a XOR b) OR (c AND d).
// PARAMETERS
//   TRUTH_TABLE  16'hF666  bit n gives f for index n = {d,c,b,a}; a is the LSB.
//   RESET_VAL    1'b0      value driven on f while rst is high.
// PORTS
//   clk  in   1  single clock; all state updates on the rising edge.
//   rst  in   1  asynchronous, active-high reset.
//   a    in   1  function input, index bit 0.
//   b    in   1  function input, index bit 1.
//   c    in   1  function input, index bit 2.
//   d    in   1  function input, index bit 3.
//   f    out  1  registered function output.
// BEHAVIOUR
//   - Index n = {d,c,b,a}, unsigned 0..15. Next value of f = TRUTH_TABLE[n].
//   - f is driven directly from a flop. No combinational path from a..d to f.
//   - Latency is 1 cycle. Inputs sampled at rising edge k appear on f after edge k.
//   - Reset:
//     - rst high forces f = RESET_VAL immediately, without waiting for a clock edge.
//     - Any synchronizer flops also clear to 0 while rst is high.
//   - Reset release: the first rising edge with rst low samples the inputs normally.
//   - Reset asserted mid-operation discards all in-flight samples. No stale value
//     appears on f after reset is released.
//   - Inputs that change between clock edges have no effect on f. Only the value at
//     the edge matters.
//   - X or Z on any input gives an unspecified f for that cycle only. There is no
//     sticky state.
//   - Default truth table, f = 1 for n in {1,2,5,6,9,10,12,13,14,15}, else 0.
//   - TRUTH_TABLE is the only function definition. No other logic may alter the mapping.
// CONFIGURATION
//   - INPUT_SYNC_EN defined:
//     - a..d each pass through a 2-flop synchronizer (reset to 0) before indexing.
//     - Total latency is 3 cycles: input at edge k appears on f after edge k+2.
//     - After reset release, f evaluates index 0 for the first 2 edges, i.e. f = TRUTH_TABLE[0].
//   - INPUT_SYNC_EN undefined:
//     - No synchronizers; latency is 1 cycle as above.
//     - Inputs must be synchronous to clk.
// TESTING
//   1. Exhaustive sweep, default table. Drive n=0..15 in order, one index per cycle.
//      Expect f bits 0,1,1,0,0,1,1,0,0,1,1,0,1,1,1,1 after latency.
//   2. Reset. Hold rst=1 with a=1,b=0 (n=1). Expect f=0 with no clock edge.
//      Release rst; the next edge gives f=1.
//   3. Async reset mid-run. Set n=15 (f=1), then pulse rst between edges.
//      Expect f=0 at once; f=1 on the first edge after release.
//   4. Mid-cycle glitch. With n=0, toggle a to 1 and back before the edge.
//      Expect f stays 0.
//   5. Parameter override. TRUTH_TABLE=16'h8000 (4-input AND).
//      Expect f=1 only for a=b=c=d=1.
//   6. INPUT_SYNC_EN build. Step n from 0 to 1 at edge k.
//      Expect f rise after edge k+2, not before.

Source files
------------

// File: rtl/ques2_c.sv
// ques2_c: registered 4-input Boolean function unit.
// The output flop holds TRUTH_TABLE[{d,c,b,a}] sampled on the rising edge of clk.
// Optional build macro INPUT_SYNC_EN inserts a 2-flop synchronizer on each of
// a..d ahead of the table lookup; total latency then becomes 3 cycles.
module ques2_c #(
  parameter logic [15:0] TRUTH_TABLE = 16'hF666,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f
);

  localparam int unsigned IDX_W = 4;

  logic [IDX_W-1:0] idx_c;
  logic             f_d;
  logic             f_q;

`ifdef INPUT_SYNC_EN
  logic [IDX_W-1:0] sync1_q;
  logic [IDX_W-1:0] sync2_q;

  // Two-stage synchronizer on the packed index; clears to 0 so reset selects index 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {d, c, b, a};
      sync2_q <= sync1_q;
    end
  end

  // Lookup index comes from the synchronized inputs
  always_comb begin
    idx_c = sync2_q;
  end
`else
  // Lookup index comes straight from the (clk-synchronous) inputs
  always_comb begin
    idx_c = {d, c, b, a};
  end
`endif

  // Table lookup; the table is the sole definition of the function
  always_comb begin
    f_d = TRUTH_TABLE[idx_c];
  end

  // Output flop; reset forces RESET_VAL without waiting for a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q <= RESET_VAL;
    end else begin
      f_q <= f_d;
    end
  end

  assign f = f_q;

endmodule

// File: tb/tb_ques2_c.sv
// Directed bench for ques2_c: default table and a 4-input AND override side by side.
module tb_ques2_c;

`ifdef INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // Hand-written truth tables, bit n = f for n = {d,c,b,a}
  localparam logic [15:0] EXP_DEF = 16'b1111_0110_0110_0110;
  localparam logic [15:0] EXP_AND = 16'b1000_0000_0000_0000;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic f_def;
  logic f_and;

  int n_checks;
  int n_fail;

  // Indices seen on the last three edges, newest in [0]
  logic [3:0] hist [0:2];

  ques2_c u_def (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f_def)
  );

  ques2_c #(.TRUTH_TABLE(16'h8000), .RESET_VAL(1'b0)) u_and (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .f(f_and)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_idx(input int n);
    {d, c, b, a} = 4'(n);
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) hist[i] = 4'd0;
  endtask

  // Advance one rising edge, sample 1 time unit later, record the sampled index
  task automatic tick();
    logic [3:0] cur;
    cur = {d, c, b, a};
    @(posedge clk);
    #1;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = cur;
  endtask

  task automatic check_both(input string tag);
    logic [3:0] src;
    logic [15:0] td;
    logic [15:0] ta;
    td  = EXP_DEF;
    ta  = EXP_AND;
    src = hist[LAT-1];
    check({tag, "_def"}, f_def, td[src]);
    check({tag, "_and"}, f_and, ta[src]);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_hist();

    // Reset with n=1: output cleared before any clock edge
    rst = 1'b1;
    set_idx(1);
    #2;
    check("reset_noedge_def", f_def, 1'b0);
    check("reset_noedge_and", f_and, 1'b0);

    // Release between edges; first edge samples n=1 (or index 0 when synchronized)
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_both("release_first");
`ifndef INPUT_SYNC_EN
    check("release_f1", f_def, 1'b1);
`endif

    // Exhaustive sweep 0..15, then flush pipeline with n=15
    for (int n = 0; n < 16; n++) begin
      set_idx(n);
      tick();
      check_both($sformatf("sweep_%0d", n));
    end
    for (int i = 0; i < LAT; i++) begin
      tick();
      check_both($sformatf("flush_%0d", i));
    end
    check("n15_def", f_def, 1'b1);
    check("n15_and", f_and, 1'b1);

    // Async reset pulse mid-cycle: immediate clear, no stale value afterwards
    #2;
    rst = 1'b1;
    #1;
    check("midrst_def", f_def, 1'b0);
    check("midrst_and", f_and, 1'b0);
    #1;
    rst = 1'b0;
    clear_hist();
    tick();
    check_both("after_midrst");
`ifndef INPUT_SYNC_EN
    check("after_midrst_f1", f_def, 1'b1);
`endif
    for (int i = 0; i < LAT; i++) begin
      tick();
      check_both($sformatf("after_midrst_%0d", i));
    end

    // Glitch on a between edges with n=0 must not reach f
    set_idx(0);
    for (int i = 0; i < LAT; i++) tick();
    check("n0_def", f_def, 1'b0);
    #2 a = 1'b1;
    #2 a = 1'b0;
    tick();
    check_both("glitch");
    check("glitch_def", f_def, 1'b0);
    for (int i = 0; i < LAT; i++) begin
      tick();
      check_both($sformatf("glitch_post_%0d", i));
    end

    // Step n 0 -> 1 at edge k: f rises only after edge k+LAT-1
    set_idx(1);
    tick();
`ifdef INPUT_SYNC_EN
    check("step_k", f_def, 1'b0);
    tick();
    check("step_k1", f_def, 1'b0);
    tick();
    check("step_k2", f_def, 1'b1);
`else
    check("step_k", f_def, 1'b1);
`endif

    // Only the all-ones index lights the AND table
    set_idx(14);
    for (int i = 0; i < LAT; i++) tick();
    check("and_14", f_and, 1'b0);
    check("def_14", f_def, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
